// File: rtl/saber_cmd_executor_pkg.sv
// Shared definitions for the SABER command executor.
// Holds the opcode values, the command-word field positions, the
// controller state encoding and small opcode classification helpers.
package saber_cmd_executor_pkg;

    // Command word layout: {len, dst_base, src_base, opcode}
    localparam int OP_LSB    = 0;
    localparam int OP_W      = 5;
    localparam int SRC_LSB   = 5;
    localparam int DST_LSB   = 15;
    localparam int LEN_LSB   = 25;
    localparam int CONST_LSB = 5;

    localparam logic [OP_W-1:0] OP_NOP   = 5'd0;
    localparam logic [OP_W-1:0] OP_COPY  = 5'd1;
    localparam logic [OP_W-1:0] OP_CLEAR = 5'd2;
    localparam logic [OP_W-1:0] OP_FILL  = 5'd3;
    localparam logic [OP_W-1:0] OP_NEG   = 5'd4;
    localparam logic [OP_W-1:0] OP_END   = 5'd31;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        HOLD
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op >= OP_COPY) && (op <= OP_NEG);
    endfunction

    function automatic logic op_is_ignored(input logic [OP_W-1:0] op);
        return (op == OP_NOP) || (op == OP_END);
    endfunction

endpackage

// File: rtl/saber_cmd_executor_addr_seq.sv
// saber_addr_seq: base + counter address generator with terminal-count flag.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - restart the count at 0
//   inc       - advance the count by one
//   base      - base address (addition wraps modulo 2^ADDR_W)
//   last      - terminal count value (len-1)
//   addr      - base + count
//   at_last   - count equals last
module saber_addr_seq #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last
);

    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    assign addr    = base + cnt;
    assign at_last = (cnt == last);

endmodule

// File: rtl/saber_cmd_executor.sv
// saber_cmd_executor: executes block-memory commands from the program
// controller as read/write bursts on a data memory with a synchronous read
// port and a write port.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   command_in            - {len, dst_base, src_base, opcode}
//   command_we0           - instruction valid (level)
//   command_we1           - constant-load strobe (level), wins over we0
//   mem_raddr / mem_rdata - read port, data one cycle after address
//   mem_waddr / mem_wdata / mem_we - write port
//   done_ins_computation  - one-cycle completion pulse
//   busy                  - high in RUN, DRAIN and DONE
//   illegal_op            - sticky flag for an unknown opcode
module saber_cmd_executor
    import saber_cmd_executor_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [34:0]       command_in,
    input  logic              command_we0,
    input  logic              command_we1,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              done_ins_computation,
    output logic              busy,
    output logic              illegal_op
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

    state_t state, state_nxt;

    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_src, cmd_dst, cmd_len;
    logic              accept;

    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] src_q, dst_q, last_q;
    logic [DATA_W-1:0] const_q;
    logic              we_q;
    logic              illegal_q;
    logic [7:0]        hold_cnt;

    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_last, w_last;

    assign cmd_op  = command_in[OP_LSB  +: OP_W];
    assign cmd_src = command_in[SRC_LSB +: ADDR_W];
    assign cmd_dst = command_in[DST_LSB +: ADDR_W];
    assign cmd_len = command_in[LEN_LSB +: ADDR_W];

    // Illegal opcodes are accepted too so they can report done.
    assign accept = (state == IDLE) && !command_we1 && command_we0 && !op_is_ignored(cmd_op);

    saber_addr_seq #(.ADDR_W(ADDR_W)) u_rd_seq (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     (state == RUN),
        .base    (src_q),
        .last    (last_q),
        .addr    (r_addr),
        .at_last (r_last)
    );

    // Write sequencer advances on each write, so it trails the read side by one.
    saber_addr_seq #(.ADDR_W(ADDR_W)) u_wr_seq (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     (we_q),
        .base    (dst_q),
        .last    (last_q),
        .addr    (w_addr),
        .at_last (w_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!op_is_legal(cmd_op) || (cmd_len == '0)) state_nxt = DONE;
                    else                                          state_nxt = RUN;
                end
            end
            RUN:     if (r_last) state_nxt = DRAIN;
            DRAIN:   if (w_last) state_nxt = DONE;
            DONE:    state_nxt = HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_NOP;
            src_q     <= '0;
            dst_q     <= '0;
            last_q    <= '0;
            const_q   <= '0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            we_q     <= (state == RUN);
            hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
            if ((state == IDLE) && command_we1) begin
                const_q <= command_in[CONST_LSB +: DATA_W];
            end
            if (accept) begin
                op_q   <= cmd_op;
                src_q  <= cmd_src;
                dst_q  <= cmd_dst;
                last_q <= cmd_len - ADDR_W'(1);
                if (!op_is_legal(cmd_op)) illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_wdata = '0;
        if (we_q) begin
            case (op_q)
                OP_COPY:  mem_wdata = mem_rdata;
                OP_FILL:  mem_wdata = const_q;
                OP_NEG:   mem_wdata = '0 - mem_rdata;
                default:  mem_wdata = '0;
            endcase
        end
    end

    assign mem_raddr            = (state == RUN) ? r_addr : '0;
    assign mem_waddr            = we_q ? w_addr : '0;
    assign mem_we               = we_q;
    assign done_ins_computation = (state == DONE);
    assign busy                 = (state == RUN) || (state == DRAIN) || (state == DONE);
    assign illegal_op           = illegal_q;

endmodule

// File: tb/tb_saber_cmd_executor.sv
module tb_saber_cmd_executor;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int HC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [34:0]   command_in = '0;
    logic          command_we0 = 1'b0;
    logic          command_we1 = 1'b0;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic          mem_we, done_ins_computation, busy, illegal_op;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem     [1024];
    logic [DW-1:0] exp_mem [1024];
    logic [DW-1:0] exp_const = '0;

    int            wk[$];
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int            dk[$];
    int            busy_n;
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];

    always #5 clk = ~clk;

    saber_cmd_executor #(.DATA_W(DW), .ADDR_W(AW), .HOLD_CYC(HC)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .command_in           (command_in),
        .command_we0          (command_we0),
        .command_we1          (command_we1),
        .mem_raddr            (mem_raddr),
        .mem_rdata            (mem_rdata),
        .mem_waddr            (mem_waddr),
        .mem_wdata            (mem_wdata),
        .mem_we               (mem_we),
        .done_ins_computation (done_ins_computation),
        .busy                 (busy),
        .illegal_op           (illegal_op)
    );

    // Data memory: synchronous read, read-before-write.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    function automatic logic [34:0] mk(input int op, input int src, input int dst, input int len);
        return {10'(len), 10'(dst), 10'(src), 5'(op)};
    endfunction

    function automatic logic [DW-1:0] ref_val(input int op, input logic [DW-1:0] s);
        case (op)
            1:       return s;
            2:       return '0;
            3:       return exp_const;
            4:       return DW'((65536 - int'(s)) % 65536);
            default: return '0;
        endcase
    endfunction

    // Reference model: element-wise op over wrapped regions, records expected writes.
    function automatic void expect_op(input int op, input int src, input int dst, input int len);
        ea.delete();
        ed.delete();
        for (int i = 0; i < len; i++) begin
            int sa = (src + i) % 1024;
            int da = (dst + i) % 1024;
            logic [DW-1:0] v = ref_val(op, exp_mem[sa]);
            ea.push_back(AW'(da));
            ed.push_back(v);
            exp_mem[da] = v;
        end
    endfunction

    function automatic void poke(input int a, input logic [DW-1:0] v);
        mem[a]     = v;
        exp_mem[a] = v;
    endfunction

    task automatic issue(input logic [34:0] c);
        command_in  = c;
        command_we0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        command_we0 = 1'b0;
    endtask

    task automatic load_const(input logic [DW-1:0] v);
        logic [34:0] c = '0;
        c[20:5]     = v;
        command_in  = c;
        command_we1 = 1'b1;
        @(posedge clk);
        exp_const = v;
        @(negedge clk);
        command_we1 = 1'b0;
    endtask

    // Observe outputs for 'limit' cycles; sample k=1 is the cycle after accept.
    task automatic collect(input int limit);
        wk.delete(); wa.delete(); wd.delete(); dk.delete();
        busy_n = 0;
        for (int k = 1; k <= limit; k++) begin
            if (mem_we === 1'b1) begin
                wk.push_back(k);
                wa.push_back(mem_waddr);
                wd.push_back(mem_wdata);
            end
            if (done_ins_computation === 1'b1) dk.push_back(k);
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({mem_we, done_ins_computation, busy, illegal_op} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {mem_we, done_ins_computation, busy, illegal_op});
        end
        total++;
        if ({mem_raddr, mem_waddr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_bus: got raddr=%0h waddr=%0h wdata=%0h want 0", mem_raddr, mem_waddr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill;
        logic [34:0] c = '0;
        int          stray = 0;
        // we1 together with a valid-looking we0 word: only the constant loads.
        c[20:5]     = 16'hA5A5;
        c[4:0]      = 5'd1;
        c[34:25]    = 10'd5;
        command_in  = c;
        command_we1 = 1'b1;
        command_we0 = 1'b1;
        @(posedge clk);
        exp_const = 16'hA5A5;
        @(negedge clk);
        command_we1 = 1'b0;
        command_we0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done_ins_computation !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) stray++;
            @(negedge clk);
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL const_load_quiet: got %0d active cycles want 0", stray);
        end
        expect_op(3, 0, 100, 3);
        issue(mk(3, 0, 100, 3));
        collect(9);
        total++;
        if (wa.size() != 3) begin
            bad++;
            $display("FAIL fill_count: got %0d want 3", wa.size());
        end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            total++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i] || wk[i] != i + 2) begin
                bad++;
                $display("FAIL fill_write%0d: got a=%0d d=%h k=%0d want a=%0d d=%h k=%0d", i, wa[i], wd[i], wk[i], ea[i], ed[i], i + 2);
            end
        end
        total++;
        if (dk.size() != 1 || dk[0] != 5) begin
            bad++;
            $display("FAIL fill_done: got %0d pulses first=%0d want 1 at 5", dk.size(), (dk.size() > 0) ? dk[0] : -1);
        end
    endtask

    task automatic test_copy;
        for (int i = 0; i < 4; i++) poke(10 + i, DW'(i + 1));
        expect_op(1, 10, 200, 4);
        issue(mk(1, 10, 200, 4));
        collect(10);
        total++;
        if (wa.size() != 4) begin
            bad++;
            $display("FAIL copy_count: got %0d want 4", wa.size());
        end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            total++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i] || wk[i] != i + 2) begin
                bad++;
                $display("FAIL copy_write%0d: got a=%0d d=%h k=%0d want a=%0d d=%h k=%0d", i, wa[i], wd[i], wk[i], ea[i], ed[i], i + 2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[200 + i] !== DW'(i + 1)) begin
                bad++;
                $display("FAIL copy_mem%0d: got %h want %h", i, mem[200 + i], DW'(i + 1));
            end
        end
        total++;
        if (dk.size() != 1 || dk[0] != 6) begin
            bad++;
            $display("FAIL copy_done: got %0d pulses first=%0d want 1 at 6", dk.size(), (dk.size() > 0) ? dk[0] : -1);
        end
        total++;
        if (busy_n != 6) begin
            bad++;
            $display("FAIL copy_busy: got %0d cycles want 6", busy_n);
        end
    endtask

    task automatic test_neg;
        poke(0, 16'd1);
        poke(1, 16'd0);
        expect_op(4, 0, 50, 2);
        issue(mk(4, 0, 50, 2));
        collect(8);
        total++;
        if (mem[50] !== exp_mem[50] || mem[51] !== exp_mem[51]) begin
            bad++;
            $display("FAIL neg_mem: got %h %h want %h %h", mem[50], mem[51], exp_mem[50], exp_mem[51]);
        end
        total++;
        if (dk.size() != 1 || dk[0] != 4 || wa.size() != 2) begin
            bad++;
            $display("FAIL neg_timing: got done=%0d writes=%0d want done at 4 writes=2", (dk.size() > 0) ? dk[0] : -1, wa.size());
        end
    endtask

    task automatic test_hold;
        logic [34:0] w1 = mk(1, 300, 400, 5);
        logic [34:0] w2 = mk(1, 300, 600, 5);
        int          d = 0;
        for (int i = 0; i < 5; i++) poke(300 + i, DW'($urandom));
        expect_op(1, 300, 400, 5);
        command_in  = w1;
        command_we0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 30 && d == 0; k++) begin
            if (done_ins_computation === 1'b1) d = k;
            else @(negedge clk);
        end
        total++;
        if (d != 7) begin
            bad++;
            $display("FAIL hold_done_latency: got %0d want 7", d);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL hold_reaccept_d%0d: got busy=%b we=%b want 0 0", k, busy, mem_we);
            end
        end
        expect_op(1, 300, 600, 5);
        command_in = w2;
        @(posedge clk);
        @(negedge clk);
        command_we0 = 1'b0;
        collect(12);
        total++;
        if (wa.size() != 5 || dk.size() != 1 || dk[0] != 7) begin
            bad++;
            $display("FAIL hold_new_word: got writes=%0d done=%0d want 5 at 7", wa.size(), (dk.size() > 0) ? dk[0] : -1);
        end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            total++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                bad++;
                $display("FAIL hold_write%0d: got a=%0d d=%h want a=%0d d=%h", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_illegal;
        issue(mk(7, 1, 2, 3));
        collect(6);
        total++;
        if (wa.size() != 0 || dk.size() != 1 || dk[0] != 1) begin
            bad++;
            $display("FAIL illegal_seq: got writes=%0d done=%0d want 0 and done at 1", wa.size(), (dk.size() > 0) ? dk[0] : -1);
        end
        total++;
        if (illegal_op !== 1'b1) begin
            bad++;
            $display("FAIL illegal_flag: got %b want 1", illegal_op);
        end
        for (int j = 0; j < 2; j++) begin
            int op = (j == 0) ? 0 : 31;
            issue(mk(op, 1, 2, 3));
            collect(6);
            total++;
            if (wa.size() != 0 || dk.size() != 0 || busy_n != 0) begin
                bad++;
                $display("FAIL ignored_op%0d: got writes=%0d done=%0d busy=%0d want 0 0 0", op, wa.size(), dk.size(), busy_n);
            end
            total++;
            if (illegal_op !== 1'b1) begin
                bad++;
                $display("FAIL illegal_sticky%0d: got %b want 1", op, illegal_op);
            end
        end
    endtask

    task automatic test_clear_wrap;
        int n = 0;
        int stray = 0;
        logic aborted = 1'b0;
        for (int i = 0; i < 4; i++) poke((1022 + i) % 1024, 16'h1111 * DW'(i + 1));
        expect_op(2, 5, 1022, 4);
        issue(mk(2, 5, 1022, 4));
        collect(10);
        total++;
        if (wa.size() != 4) begin
            bad++;
            $display("FAIL wrap_count: got %0d want 4", wa.size());
        end
        for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
            total++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                bad++;
                $display("FAIL wrap_write%0d: got a=%0d d=%h want a=%0d d=%h", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        // Same command again, aborted by reset after its second write.
        for (int i = 0; i < 4; i++) poke((1022 + i) % 1024, 16'h2222 * DW'(i + 1));
        issue(mk(2, 5, 1022, 4));
        for (int k = 1; k <= 8 && !aborted; k++) begin
            if (mem_we === 1'b1) begin
                total++;
                if (mem_waddr !== AW'((1022 + n) % 1024) || mem_wdata !== '0) begin
                    bad++;
                    $display("FAIL abort_write%0d: got a=%0d d=%h want a=%0d d=0", n, mem_waddr, mem_wdata, (1022 + n) % 1024);
                end
                n++;
            end
            if (n == 2) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end
            @(negedge clk);
        end
        exp_mem[1022] = '0;
        exp_mem[1023] = '0;
        exp_const     = '0;
        total++;
        if (!aborted || {mem_we, done_ins_computation, busy, illegal_op, mem_raddr, mem_waddr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: got we=%b done=%b busy=%b ill=%b ra=%0h wa=%0h wd=%0h want all 0", mem_we, done_ins_computation, busy, illegal_op, mem_raddr, mem_waddr, mem_wdata);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (mem_we !== 1'b0 || done_ins_computation !== 1'b0) stray++;
            @(negedge clk);
        end
        total++;
        if (stray != 0 || mem[0] !== exp_mem[0] || mem[1] !== exp_mem[1]) begin
            bad++;
            $display("FAIL abort_after: got stray=%0d m0=%h m1=%h want 0 %h %h", stray, mem[0], mem[1], exp_mem[0], exp_mem[1]);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 25; it++) begin
            int op  = $urandom_range(1, 4);
            int len = $urandom_range(1, 12);
            int src = $urandom_range(0, 1023);
            int dst = (src + 16 + $urandom_range(0, 900)) % 1024;
            if ($urandom_range(0, 2) == 0) load_const(DW'($urandom));
            expect_op(op, src, dst, len);
            issue(mk(op, src, dst, len));
            collect(len + 6);
            total++;
            if (wa.size() != len || dk.size() != 1 || dk[0] != len + 2) begin
                bad++;
                $display("FAIL rand%0d_shape: got writes=%0d done=%0d want %0d at %0d", it, wa.size(), (dk.size() > 0) ? dk[0] : -1, len, len + 2);
            end
            for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
                total++;
                if (wa[i] !== ea[i] || wd[i] !== ed[i] || wk[i] != i + 2) begin
                    bad++;
                    $display("FAIL rand%0d_write%0d: got a=%0d d=%h k=%0d want a=%0d d=%h k=%0d", it, i, wa[i], wd[i], wk[i], ea[i], ed[i], i + 2);
                end
            end
        end
    endtask

    task automatic test_memory_image;
        int diffs = 0;
        for (int a = 0; a < 1024; a++) if (mem[a] !== exp_mem[a]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL memory_image: got %0d differing words want 0", diffs);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 1024; a++) poke(a, DW'($urandom));
        test_reset();
        test_fill();
        test_copy();
        test_neg();
        test_hold();
        test_illegal();
        test_clear_wrap();
        test_random();
        test_memory_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
